vram_write_scheduler: RTL and testbench
=======================================

Name: vram_write_scheduler

Overview:
- Owns the single write port of the 32x32, 3-bit video memory.
- Shares that port between two requesters: CPU single-pixel writes (WVM instruction) and a hardware rectangle-fill engine (screen clear, block paint).
- Sits between the CPU execute stage and the video memory write port. The CPU cannot stall, so CPU writes always win; the fill engine advances only on cycles the CPU leaves free.

Parameters:
- COLS_LOG2, 5, log2 of tile columns; X coordinate width.
- ROWS_LOG2, 5, log2 of tile rows; Y coordinate width.
- COLOR_W, 3, pixel colour width (R,G,B).

Ports:
- Clock  input  1  system clock, posedge.
- Reset  input  1  synchronous, active-high.
- iCpuWrite  input  1  CPU write request, single-cycle qualifier.
- iCpuAddress  input  ROWS_LOG2+COLS_LOG2  CPU write address {y,x}.
- iCpuColor  input  COLOR_W  CPU write colour.
- iFillStart  input  1  start pulse for a rectangle fill.
- iFillX0  input  COLS_LOG2  left column, inclusive.
- iFillY0  input  ROWS_LOG2  top row, inclusive.
- iFillX1  input  COLS_LOG2  right column, inclusive.
- iFillY1  input  ROWS_LOG2  bottom row, inclusive.
- iFillColor  input  COLOR_W  fill colour.
- oWriteEnable  output  1  video memory write enable.
- oWriteAddress  output  ROWS_LOG2+COLS_LOG2  video memory write address {y,x}.
- oDataOut  output  COLOR_W  video memory write data.
- oBusy  output  1  high while the fill is in progress.
- oDone  output  1  one-cycle pulse when a fill finishes or is rejected.
- oError  output  1  sticky; last fill was rejected as an invalid rectangle.

Behaviour:
- All outputs are registered. Reset drives every output to 0, forces state IDLE and clears all counters.
- Latency: a request sampled at edge N appears on the write port after edge N, i.e. one cycle.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - iFillStart=1 latches X0, Y0, X1, Y1 and colour, clears oError, and sets the cursor to (X0,Y0).
  - If X1<X0 or Y1<Y0 (unsigned): go to DONE with oError=1; no pixel is written.
  - Otherwise: go to FILL.
- FILL:
  - oBusy=1.
  - Each cycle with iCpuWrite=0: emit one fill write at the cursor, then advance the cursor.
  - Cursor advance is row-major: x++; when x==X1, x<=X0 and y++.
  - When the write at (X1,Y1) is emitted, go to DONE.
- DONE: oDone=1 for exactly one cycle, oBusy=0, then return to IDLE. iFillStart in DONE is accepted exactly as in IDLE (back-to-back fills).
- Arbitration:
  - iCpuWrite=1 in any state: the port carries the CPU address and colour.
  - In FILL, the fill cursor holds that cycle; no fill pixel is lost or duplicated.
- Fill duration: (X1-X0+1)*(Y1-Y0+1) + number of CPU-write cycles during FILL, counted from the cycle after start.
- iFillStart in FILL is ignored, and the latched rectangle is unchanged.
- Cursor arithmetic needs no wrap: X1 and Y1 are at most 31, so the counters never overflow. A full screen (0,0)-(31,31) is 1024 writes.
- Single-tile rectangle (X0=X1, Y0=Y1): exactly one write, then DONE.
- Reset mid-fill: abort immediately, no further writes, no oDone pulse.
- No write is emitted in IDLE or DONE unless iCpuWrite=1.

Optional Feature:
- Macro: VRAM_FILL_CHECKER_EN.
- Defined: fill colour per pixel = iFillColor latched when cursor (x^y) bit0 = 0, else its bitwise complement. This produces a checkerboard pattern.
- Undefined: every fill pixel uses the latched iFillColor. No extra logic.

Test Plan:
- Reset, then fill (0,0)-(31,31) colour 3'b000 with no CPU traffic -> 1024 consecutive writes, addresses 0..1023 in order; oBusy high for 1024 cycles; one oDone pulse; oError=0.
- Fill (2,3)-(4,4) colour 3'b101 while CPU writes addr 10'h3FF colour 3'b010 on the 2nd fill cycle:
  - First fill write is {3,2}=10'h062.
  - Next cycle the CPU write (10'h3FF, 3'b010) appears on the port.
  - Fill resumes at {3,3}; 6 fill writes in total, finishing at {4,4}.
  - oDone arrives 7 cycles after the first fill write.
- Invalid rectangle (5,0)-(4,0) -> no write; oDone pulse the cycle after start; oError=1 stays high until the next iFillStart.
- Start pulse during a running fill of (0,0)-(31,0) with a different rectangle -> ignored; exactly 32 writes at addresses 0..31.
- Assert Reset at the 10th write of a full-screen fill -> oWriteEnable=0 from the next cycle; oBusy=0; no oDone; the next start begins cleanly.
- With VRAM_FILL_CHECKER_EN, fill (0,0)-(1,1) colour 3'b100 -> written data 100, 011, 011, 100 at addresses 0, 1, 32, 33.

Source files
------------

// File: rtl/vram_write_scheduler_if.sv
// vram_write_scheduler_if
//   Bundles the two requesters (CPU single-pixel write, rectangle-fill start)
//   and the video memory write port of vram_write_scheduler.
//
//   Handshake semantics: there is no ready signal. cpu_write is a
//   single-cycle qualifier that is always accepted and always wins the port.
//   fill_start is a single-cycle pulse that is accepted only while busy is
//   low (IDLE or DONE). A pulse seen while busy is high is dropped.
//
//   Modports
//     master : requester side (drives requests, observes port and status)
//     slave  : scheduler side (consumes requests, drives port and status)
//
//   Signals
//     cpu_write / cpu_address / cpu_color : CPU write request, address {y,x}
//     fill_start, fill_x0/y0/x1/y1, fill_color : rectangle fill request
//     write_enable / write_address / data_out : video memory write port
//     busy  : fill in progress
//     done  : one-cycle pulse when a fill finishes or is rejected
//     error : sticky, last fill rejected as an invalid rectangle
//     fsm_state : debug view of the scheduler FSM state
interface vram_write_scheduler_if #(
  parameter int COLS_LOG2 = 5,
  parameter int ROWS_LOG2 = 5,
  parameter int COLOR_W   = 3
);
  localparam int ADDR_W = ROWS_LOG2 + COLS_LOG2;

  logic                 cpu_write;
  logic [ADDR_W-1:0]    cpu_address;
  logic [COLOR_W-1:0]   cpu_color;

  logic                 fill_start;
  logic [COLS_LOG2-1:0] fill_x0;
  logic [ROWS_LOG2-1:0] fill_y0;
  logic [COLS_LOG2-1:0] fill_x1;
  logic [ROWS_LOG2-1:0] fill_y1;
  logic [COLOR_W-1:0]   fill_color;

  logic                 write_enable;
  logic [ADDR_W-1:0]    write_address;
  logic [COLOR_W-1:0]   data_out;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [1:0]           fsm_state;

  modport master (
    output cpu_write, cpu_address, cpu_color,
    output fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    input  write_enable, write_address, data_out, busy, done, error, fsm_state
  );

  modport slave (
    input  cpu_write, cpu_address, cpu_color,
    input  fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    output write_enable, write_address, data_out, busy, done, error, fsm_state
  );
endinterface

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Owns the single write port of the video memory and shares it between
//   CPU single-pixel writes and a rectangle-fill engine. The CPU cannot
//   stall, so a CPU write always takes the port; the fill cursor only
//   advances on cycles without a CPU write. Every output is registered:
//   a request sampled at edge N is on the port after edge N.
//
//   Ports
//     clk : system clock, rising edge
//     rst : synchronous, active-high reset (aborts a running fill silently)
//     bus : vram_write_scheduler_if.slave (requests in, write port/status out)
//
//   Build option
//     VRAM_FILL_CHECKER_EN : when defined, fill pixels whose (x ^ y) bit 0 is
//     set use the complement of the fill colour, giving a checkerboard.
module vram_write_scheduler #(
  parameter int COLS_LOG2 = 5,
  parameter int ROWS_LOG2 = 5,
  parameter int COLOR_W   = 3
) (
  input logic                   clk,
  input logic                   rst,
  vram_write_scheduler_if.slave bus
);
  localparam int ADDR_W = ROWS_LOG2 + COLS_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;

  // Latched rectangle. Y0 is only needed to seed the cursor, since the row
  // counter only moves forward, so it is not kept.
  logic [COLS_LOG2-1:0] x0_q, x0_d;
  logic [COLS_LOG2-1:0] x1_q, x1_d;
  logic [ROWS_LOG2-1:0] y1_q, y1_d;
  logic [COLOR_W-1:0]   color_q, color_d;

  logic [COLS_LOG2-1:0] cx_q, cx_d;
  logic [ROWS_LOG2-1:0] cy_q, cy_d;

  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COLOR_W-1:0]   data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic [COLOR_W-1:0]   fill_pixel;

`ifdef VRAM_FILL_CHECKER_EN
  assign fill_pixel = (cx_q[0] ^ cy_q[0]) ? ~color_q : color_q;
`else
  assign fill_pixel = color_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    done_d  = 1'b0;
    error_d = error_q;

    case (state_q)
      IDLE, DONE: begin
        // The done pulse is produced on the edge that leaves DONE, so it
        // lands one cycle after the last fill write (or after a rejection).
        done_d  = (state_q == DONE);
        state_d = IDLE;
        if (bus.fill_start) begin
          x0_d    = bus.fill_x0;
          x1_d    = bus.fill_x1;
          y1_d    = bus.fill_y1;
          color_d = bus.fill_color;
          cx_d    = bus.fill_x0;
          cy_d    = bus.fill_y0;
          error_d = 1'b0;
          if ((bus.fill_x1 < bus.fill_x0) || (bus.fill_y1 < bus.fill_y0)) begin
            state_d = DONE;
            error_d = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        // A CPU write this cycle freezes the cursor; the pixel is retried.
        if (!bus.cpu_write) begin
          we_d   = 1'b1;
          addr_d = {cy_q, cx_q};
          data_d = fill_pixel;
          if (cx_q == x1_q) begin
            if (cy_q == y1_q) begin
              state_d = DONE;
            end else begin
              cx_d = x0_q;
              cy_d = cy_q + ROWS_LOG2'(1);
            end
          end else begin
            cx_d = cx_q + COLS_LOG2'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (bus.cpu_write) begin
      we_d   = 1'b1;
      addr_d = bus.cpu_address;
      data_d = bus.cpu_color;
    end

    busy_d = (state_d == FILL);
  end

  assign bus.write_enable  = we_q;
  assign bus.write_address = addr_q;
  assign bus.data_out      = data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler
//   Directed bench for vram_write_scheduler. Inputs are driven 1 ns after a
//   rising edge and outputs are sampled at the same point, so each tick()
//   shows the result of the inputs presented before that edge. Every write
//   on the port is matched in order against exp_q.
module tb_vram_write_scheduler;
  localparam int CL = 5;
  localparam int RL = 5;
  localparam int CW = 3;
  localparam int AW = CL + RL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_write_scheduler_if #(.COLS_LOG2(CL), .ROWS_LOG2(RL), .COLOR_W(CW)) bus ();

  vram_write_scheduler #(.COLS_LOG2(CL), .ROWS_LOG2(RL), .COLOR_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [AW+CW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- clock/reset and driver tasks ----------------
  task automatic tick();
    logic [AW+CW-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.write_enable === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(bus.write_enable), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr", 32'({bus.write_address, bus.data_out}), 32'(e));
      end
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic drive_idle();
    bus.cpu_write   = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_color   = '0;
    bus.fill_start  = 1'b0;
    bus.fill_x0     = '0;
    bus.fill_y0     = '0;
    bus.fill_x1     = '0;
    bus.fill_y1     = '0;
    bus.fill_color  = '0;
  endtask

  task automatic clear_counts();
    wr_cnt   = 0;
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic set_rect(input int x0, input int y0, input int x1, input int y1,
                          input logic [CW-1:0] col);
    bus.fill_x0    = CL'(x0);
    bus.fill_y0    = RL'(y0);
    bus.fill_x1    = CL'(x1);
    bus.fill_y1    = RL'(y1);
    bus.fill_color = col;
  endtask

  task automatic start_fill(input int x0, input int y0, input int x1, input int y1,
                            input logic [CW-1:0] col);
    set_rect(x0, y0, x1, y1, col);
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [CW-1:0] c);
    bus.cpu_write   = 1'b1;
    bus.cpu_address = a;
    bus.cpu_color   = c;
    tick();
    bus.cpu_write   = 1'b0;
  endtask

  task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                           input logic [CW-1:0] col);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        exp_q.push_back({RL'(y), CL'(x), col});
  endtask

  task automatic run_until_done(input string tag, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int first_cyc;
    logic found;

    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_we",    32'(bus.write_enable),  32'd0);
    check("rst_addr",  32'(bus.write_address), 32'd0);
    check("rst_data",  32'(bus.data_out),      32'd0);
    check("rst_busy",  32'(bus.busy),          32'd0);
    check("rst_done",  32'(bus.done),          32'd0);
    check("rst_error", 32'(bus.error),         32'd0);
    check("rst_state", 32'(bus.fsm_state),     32'd0);
    rst = 1'b0;
    tick();

    // Full screen, no CPU traffic: 1024 writes at 0..1023 in order.
    clear_counts();
    push_rect(0, 0, 31, 31, 3'b000);
    start_fill(0, 0, 31, 31, 3'b000);
    run_until_done("full", 1100);
    check("full_writes", 32'(wr_cnt),       32'd1024);
    check("full_busy",   32'(busy_cnt),     32'd1024);
    check("full_done",   32'(done_cnt),     32'd1);
    check("full_error",  32'(bus.error),    32'd0);
    check("full_left",   32'(exp_q.size()), 32'd0);
    tick();
    check("full_done_width", 32'(bus.done), 32'd0);

    // CPU write steals the 2nd fill cycle.
    clear_counts();
    exp_q.push_back({10'h062, 3'b101});
    exp_q.push_back({10'h3FF, 3'b010});
    exp_q.push_back({10'h063, 3'b101});
    exp_q.push_back({10'h064, 3'b101});
    exp_q.push_back({10'h082, 3'b101});
    exp_q.push_back({10'h083, 3'b101});
    exp_q.push_back({10'h084, 3'b101});
    start_fill(2, 3, 4, 4, 3'b101);
    tick();
    first_cyc = cyc;
    check("arb_first_we", 32'(bus.write_enable), 32'd1);
    cpu_write(10'h3FF, 3'b010);
    check("arb_busy_cpu", 32'(bus.busy), 32'd1);
    run_until_done("arb", 20);
    check("arb_done_latency", 32'(cyc - first_cyc), 32'd7);
    check("arb_writes",       32'(wr_cnt),          32'd7);
    check("arb_left",         32'(exp_q.size()),    32'd0);

    // Invalid rectangle, CPU write in IDLE, then a single-tile fill.
    clear_counts();
    start_fill(5, 0, 4, 0, 3'b111);
    check("inv_we",    32'(bus.write_enable), 32'd0);
    check("inv_error", 32'(bus.error),        32'd1);
    check("inv_busy",  32'(bus.busy),         32'd0);
    tick();
    check("inv_done",  32'(bus.done),         32'd1);
    check("inv_we2",   32'(bus.write_enable), 32'd0);
    tick();
    check("inv_done_width", 32'(bus.done),  32'd0);
    check("inv_error_hold", 32'(bus.error), 32'd1);
    exp_q.push_back({10'h155, 3'b111});
    cpu_write(10'h155, 3'b111);
    check("idle_cpu_writes", 32'(wr_cnt),    32'd1);
    check("idle_error_hold", 32'(bus.error), 32'd1);
    exp_q.push_back({10'h0E7, 3'b110});
    start_fill(7, 7, 7, 7, 3'b110);
    check("tile_error_clr", 32'(bus.error), 32'd0);
    run_until_done("tile", 10);
    check("tile_writes", 32'(wr_cnt),       32'd2);
    check("tile_left",   32'(exp_q.size()), 32'd0);

    // Start pulse during a running fill is ignored.
    clear_counts();
    push_rect(0, 0, 31, 0, 3'b001);
    start_fill(0, 0, 31, 0, 3'b001);
    repeat (5) tick();
    set_rect(10, 10, 12, 12, 3'b111);
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    run_until_done("ign", 60);
    check("ign_writes", 32'(wr_cnt),       32'd32);
    check("ign_left",   32'(exp_q.size()), 32'd0);

    // Back-to-back: next start accepted in DONE.
    clear_counts();
    push_rect(0, 1, 1, 1, 3'b010);
    exp_q.push_back({10'h042, 3'b011});
    start_fill(0, 1, 1, 1, 3'b010);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.write_enable === 1'b1 && bus.busy === 1'b0) found = 1'b1;
    end
    check("b2b_last_write", 32'(found), 32'd1);
    start_fill(2, 2, 2, 2, 3'b011);
    check("b2b_done", 32'(bus.done), 32'd1);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    run_until_done("b2b", 10);
    check("b2b_done_cnt", 32'(done_cnt),     32'd2);
    check("b2b_left",     32'(exp_q.size()), 32'd0);

    // Reset at the 10th write of a full-screen fill.
    clear_counts();
    for (int i = 0; i < 10; i++) exp_q.push_back({AW'(i), 3'b000});
    start_fill(0, 0, 31, 31, 3'b000);
    for (int i = 0; i < 20 && wr_cnt < 10; i++) tick();
    check("rstm_writes_before", 32'(wr_cnt), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstm_we",   32'(bus.write_enable), 32'd0);
    check("rstm_busy", 32'(bus.busy),         32'd0);
    repeat (3) tick();
    check("rstm_no_done",  32'(done_cnt), 32'd0);
    check("rstm_no_extra", 32'(wr_cnt),   32'd10);
    exp_q.push_back({10'h000, 3'b010});
    start_fill(0, 0, 0, 0, 3'b010);
    run_until_done("rstm", 10);
    check("rstm_restart_writes", 32'(wr_cnt),       32'd11);
    check("rstm_left",           32'(exp_q.size()), 32'd0);

    // 2x2 fill: checkerboard when the build option is on.
    clear_counts();
`ifdef VRAM_FILL_CHECKER_EN
    exp_q.push_back({10'd0,  3'b100});
    exp_q.push_back({10'd1,  3'b011});
    exp_q.push_back({10'd32, 3'b011});
    exp_q.push_back({10'd33, 3'b100});
`else
    exp_q.push_back({10'd0,  3'b100});
    exp_q.push_back({10'd1,  3'b100});
    exp_q.push_back({10'd32, 3'b100});
    exp_q.push_back({10'd33, 3'b100});
`endif
    start_fill(0, 0, 1, 1, 3'b100);
    run_until_done("chk", 10);
    check("chk_writes", 32'(wr_cnt),       32'd4);
    check("chk_left",   32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
